// File: rtl/reg_dst_tracker.sv
// Write-back destination selector with an in-order queue of pending destinations
// and read-after-write hazard flags for the two decode source fields.
module reg_dst_tracker #(
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [1:0]        Control,
  input  logic [ADDR_W-1:0] OneInput,
  input  logic [ADDR_W-1:0] TwoInput,
  input  logic              IssueValid,
  output logic              IssueReady,
  input  logic              RetireValid,
  input  logic [ADDR_W-1:0] SrcA,
  input  logic [ADDR_W-1:0] SrcB,
  output logic [ADDR_W-1:0] DataOutput,
  output logic              DestValid,
  output logic [ADDR_W-1:0] RetireDest,
  output logic              HazardA,
  output logic              HazardB,
  output logic [CNT_W-1:0]  Count,
  output logic              SelError
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_q [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_data;
  logic              r_dest_vld;
  logic              r_sel_err;

  logic              w_empty;
  logic              w_ready;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_sel;
  logic              w_haz_a;
  logic              w_haz_b;

  assign w_empty   = (r_count == '0);
  assign w_ready   = (r_count < CNT_W'(DEPTH)) || RetireValid;
  assign w_illegal = IssueValid && (Control == 2'b11);
  assign w_push    = IssueValid && w_ready && (Control != 2'b11);
  assign w_pop     = RetireValid && !w_empty;

  always_comb begin
    w_sel = ADDR_W'(LINK_REG);
    case (Control)
      2'b01:   w_sel = OneInput;
      2'b10:   w_sel = TwoInput;
      default: w_sel = ADDR_W'(LINK_REG);
    endcase
  end

  // Only registered entries are compared: the one being pushed is not yet
  // visible, the one being popped still is.
  always_comb begin
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_q[i] == SrcA)) w_haz_a = 1'b1;
      if (r_vld[i] && (r_q[i] == SrcB)) w_haz_b = 1'b1;
    end
    if (SrcA == '0) w_haz_a = 1'b0;
    if (SrcB == '0) w_haz_b = 1'b0;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_vld      <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_dest_vld <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_dest_vld <= w_push;
      r_sel_err  <= w_illegal || (RetireValid && w_empty);
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
      end
      // Push after pop so a full-queue push+pop into the same slot stays valid.
      if (w_push) begin
        r_q[r_tail]   <= w_sel;
        r_vld[r_tail] <= 1'b1;
        r_data        <= w_sel;
        r_tail <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);
      end
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign IssueReady = w_ready;
  assign DataOutput = r_data;
  assign DestValid  = r_dest_vld;
  assign RetireDest = w_empty ? '0 : r_q[r_head];
  assign HazardA    = w_haz_a;
  assign HazardB    = w_haz_b;
  assign Count      = r_count;
  assign SelError   = r_sel_err;

endmodule

// File: tb/tb_reg_dst_tracker.sv
// Directed bench for reg_dst_tracker with DEPTH=4, ADDR_W=5, LINK_REG=31.
module tb_reg_dst_tracker;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [1:0] Control;
  logic [4:0] OneInput, TwoInput, SrcA, SrcB;
  logic       IssueValid, RetireValid;
  logic       IssueReady, DestValid, HazardA, HazardB, SelError;
  logic [4:0] DataOutput, RetireDest;
  logic [2:0] Count;

  int n_assert = 0;
  int n_fail   = 0;

  reg_dst_tracker #(.ADDR_W(5), .LINK_REG(31), .DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .Control(Control), .OneInput(OneInput),
    .TwoInput(TwoInput), .IssueValid(IssueValid), .IssueReady(IssueReady),
    .RetireValid(RetireValid), .SrcA(SrcA), .SrcB(SrcB),
    .DataOutput(DataOutput), .DestValid(DestValid), .RetireDest(RetireDest),
    .HazardA(HazardA), .HazardB(HazardB), .Count(Count), .SelError(SelError)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] ctl, input logic [4:0] one, input logic [4:0] two);
    IssueValid = 1'b1; Control = ctl; OneInput = one; TwoInput = two;
    tick();
    IssueValid = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; Control = 2'b00; OneInput = '0; TwoInput = '0;
    IssueValid = 1'b0; RetireValid = 1'b0; SrcA = '0; SrcB = '0;
    #12;
    chk("rst_count", Count, 0);
    chk("rst_data", DataOutput, 0);
    chk("rst_destvld", DestValid, 0);
    chk("rst_selerr", SelError, 0);
    chk("rst_retdest", RetireDest, 0);
    chk("rst_hazA", HazardA, 0);
    chk("rst_hazB", HazardB, 0);
    chk("rst_ready", IssueReady, 1);
    Reset = 1'b1;
    tick();

    // Three selections, one per cycle
    IssueValid = 1'b1;
    Control = 2'b00; tick();
    chk("sel_link_data", DataOutput, 31);
    chk("sel_link_dv", DestValid, 1);
    Control = 2'b01; OneInput = 5'd8; tick();
    chk("sel_rt_data", DataOutput, 8);
    chk("sel_rt_dv", DestValid, 1);
    Control = 2'b10; TwoInput = 5'd17; tick();
    chk("sel_rd_data", DataOutput, 17);
    chk("sel_rd_dv", DestValid, 1);
    chk("sel_count", Count, 3);
    chk("sel_head", RetireDest, 31);

    // Illegal select
    Control = 2'b11; tick();
    IssueValid = 1'b0;
    chk("ill_selerr", SelError, 1);
    chk("ill_count", Count, 3);
    chk("ill_data", DataOutput, 17);
    chk("ill_dv", DestValid, 0);
    tick();
    chk("ill_selerr_clr", SelError, 0);

    // Hazards on pending {31,8,17}
    SrcA = 5'd8; SrcB = 5'd0; #1;
    chk("haz_a8", HazardA, 1);
    chk("haz_b0", HazardB, 0);
    SrcB = 5'd17; #1;
    chk("haz_b17", HazardB, 1);
    SrcA = 5'd31; RetireValid = 1'b1; #1;
    chk("haz_popping_still", HazardA, 1);
    tick(); tick();
    RetireValid = 1'b0;
    SrcA = 5'd8; #1;
    chk("ret2_count", Count, 1);
    chk("ret2_head", RetireDest, 17);
    chk("ret2_hazA", HazardA, 0);

    // Fill to DEPTH with wrap; destination 0 is queued but never hazards
    issue(2'b01, 5'd0, 5'd0);
    issue(2'b10, 5'd0, 5'd3);
    issue(2'b10, 5'd0, 5'd9);
    chk("full_count", Count, 4);
    chk("full_ready", IssueReady, 0);
    SrcA = 5'd0; #1;
    chk("zero_nohaz", HazardA, 0);
    issue(2'b10, 5'd0, 5'd20);
    chk("full_reject_count", Count, 4);
    chk("full_reject_dv", DestValid, 0);
    chk("full_reject_data", DataOutput, 9);

    // Simultaneous push+pop at full
    IssueValid = 1'b1; Control = 2'b10; TwoInput = 5'd5; RetireValid = 1'b1;
    SrcA = 5'd5; #1;
    chk("pp_ready", IssueReady, 1);
    chk("pp_push_not_cmp", HazardA, 0);
    tick();
    IssueValid = 1'b0; RetireValid = 1'b0; #1;
    chk("pp_count", Count, 4);
    chk("pp_head", RetireDest, 0);
    chk("pp_data", DataOutput, 5);
    chk("pp_haz_tail", HazardA, 1);

    // Drain in order {0,3,9,5}
    RetireValid = 1'b1;
    chk("drain0", RetireDest, 0); tick();
    chk("drain1", RetireDest, 3); tick();
    chk("drain2", RetireDest, 9); tick();
    chk("drain3", RetireDest, 5); tick();
    RetireValid = 1'b0;
    chk("drain_count", Count, 0);
    chk("drain_empty_head", RetireDest, 0);

    // Retire on empty
    RetireValid = 1'b1; tick();
    RetireValid = 1'b0;
    chk("empty_ret_selerr", SelError, 1);
    chk("empty_ret_count", Count, 0);
    issue(2'b10, 5'd0, 5'd12);
    chk("after_empty_count", Count, 1);
    chk("after_empty_head", RetireDest, 12);
    RetireValid = 1'b1; tick();
    RetireValid = 1'b0;
    chk("after_empty_ret", Count, 0);

    // Asynchronous reset mid-stream with Count=3
    issue(2'b01, 5'd4, 5'd0);
    issue(2'b10, 5'd0, 5'd6);
    issue(2'b00, 5'd0, 5'd0);
    chk("pre_rst_count", Count, 3);
    SrcA = 5'd6; SrcB = 5'd4; #2;
    Reset = 1'b0; #1;
    chk("mid_rst_count", Count, 0);
    chk("mid_rst_data", DataOutput, 0);
    chk("mid_rst_hazA", HazardA, 0);
    chk("mid_rst_hazB", HazardB, 0);
    chk("mid_rst_ready", IssueReady, 1);
    chk("mid_rst_head", RetireDest, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
